run_length_detector: RTL and testbench

RUN_LENGTH_DETECTOR -- requirements
Module: run_length_detector

---
 rtl/run_length_detector.sv | 145 ++++++++++++++
 tb/tb_run_length_detector.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_length_detector.sv
// Run-length detector: measures runs of a chosen bit value on a gated serial
// stream. It reports each completed run's length, flags lengths selected by a
// mask, counts those matches, and remembers whether any run hit the counter
// ceiling.
module run_length_detector #(
    parameter int CNT_W = 5,
    parameter int EVT_W = 8,
    parameter int ONES  = 1
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  CLR,
    input  logic                  EN,
    input  logic                  BIT,
    input  logic [2**CNT_W-1:0]   LEN_MASK,
    output logic [1:0]            STATE,
    output logic [CNT_W-1:0]      COUNT,
    output logic                  MATCH,
    output logic                  RUN_VALID,
    output logic [CNT_W-1:0]      RUN_LEN,
    output logic                  SAT,
    output logic [EVT_W-1:0]      MATCH_CNT
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        OVF  = 2'd2
    } state_e;

    // Longest run the counter can represent; the counter sticks here.
    localparam logic [CNT_W-1:0] MAXR = '1;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] run_len_q, run_len_d;
    logic             match_q, match_d;
    logic             run_valid_q, run_valid_d;
    logic             sat_q, sat_d;
    logic [EVT_W-1:0] match_cnt_q, match_cnt_d;
    logic             run_bit;

    // Next-state logic: clear beats enable, enable gates the normal update.
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path
        // leaves one unassigned; an unassigned path would infer a latch.
        state_d     = state_q;
        count_d     = count_q;
        run_len_d   = run_len_q;
        sat_d       = sat_q;
        match_cnt_d = match_cnt_q;
        match_d     = 1'b0;
        run_valid_d = 1'b0;
        run_bit     = (ONES != 0) ? BIT : ~BIT;

        if (CLR) begin
            // A run in progress is dropped silently; the last length is kept.
            state_d     = IDLE;
            count_d     = '0;
            sat_d       = 1'b0;
            match_cnt_d = '0;
        end else if (EN) begin
            unique case (state_q)
                IDLE: begin
                    if (run_bit) begin
                        count_d = CNT_W'(1);
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (run_bit) begin
                        if (count_q == MAXR) begin
                            // One bit past the ceiling: the length is now unknown.
                            state_d = OVF;
                        end else begin
                            count_d = count_q + CNT_W'(1);
                        end
                    end else begin
                        run_valid_d = 1'b1;
                        run_len_d   = count_q;
                        count_d     = '0;
                        state_d     = IDLE;
                        // Mask is looked up live at the end of the run.
                        if (LEN_MASK[count_q]) begin
                            match_d = 1'b1;
                            if (match_cnt_q != '1) begin
                                match_cnt_d = match_cnt_q + EVT_W'(1);
                            end
                        end
                    end
                end
                OVF: begin
                    if (!run_bit) begin
                        // Overflowed runs report MAXR but never count as a match.
                        run_valid_d = 1'b1;
                        run_len_d   = count_q;
                        count_d     = '0;
                        state_d     = IDLE;
                    end
                end
                default: begin
                    state_d = IDLE;
                    count_d = '0;
                end
            endcase

            // Sticky ceiling flag: any run whose count reaches MAXR.
            if (count_d == MAXR) begin
                sat_d = 1'b1;
            end
        end
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q     <= IDLE;
            count_q     <= '0;
            run_len_q   <= '0;
            match_q     <= 1'b0;
            run_valid_q <= 1'b0;
            sat_q       <= 1'b0;
            match_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the
            // pre-edge values, independent of statement order.
            state_q     <= state_d;
            count_q     <= count_d;
            run_len_q   <= run_len_d;
            match_q     <= match_d;
            run_valid_q <= run_valid_d;
            sat_q       <= sat_d;
            match_cnt_q <= match_cnt_d;
        end
    end

    assign STATE     = state_q;
    assign COUNT     = count_q;
    assign MATCH     = match_q;
    assign RUN_VALID = run_valid_q;
    assign RUN_LEN   = run_len_q;
    assign SAT       = sat_q;
    assign MATCH_CNT = match_cnt_q;

endmodule

// File: tb/tb_run_length_detector.sv
// Bench for run_length_detector: directed scenarios plus randomized traffic,
// all checked against a run-length model kept as a plain integer count.
module tb_run_length_detector;

    localparam int CNT_W = 5;
    localparam int MAXR  = 2**CNT_W - 1;

    logic              CLK;
    logic              RESET;
    logic              CLR;
    logic              EN;
    logic              BIT;
    logic [31:0]       LEN_MASK;

    logic [1:0]        state_a;
    logic [CNT_W-1:0]  count_a;
    logic              match_a;
    logic              run_valid_a;
    logic [CNT_W-1:0]  run_len_a;
    logic              sat_a;
    logic [7:0]        match_cnt_a;

    logic [1:0]        state_b;
    logic [CNT_W-1:0]  count_b;
    logic              match_b;
    logic              run_valid_b;
    logic [CNT_W-1:0]  run_len_b;
    logic              sat_b;
    logic [1:0]        match_cnt_b;

    run_length_detector #(.CNT_W(CNT_W), .EVT_W(8), .ONES(1)) dut (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .EN(EN), .BIT(BIT),
        .LEN_MASK(LEN_MASK),
        .STATE(state_a), .COUNT(count_a), .MATCH(match_a),
        .RUN_VALID(run_valid_a), .RUN_LEN(run_len_a), .SAT(sat_a),
        .MATCH_CNT(match_cnt_a)
    );

    // Narrow event counter instance to exercise saturation quickly.
    run_length_detector #(.CNT_W(CNT_W), .EVT_W(2), .ONES(1)) dut_narrow (
        .CLK(CLK), .RESET(RESET), .CLR(CLR), .EN(EN), .BIT(BIT),
        .LEN_MASK(LEN_MASK),
        .STATE(state_b), .COUNT(count_b), .MATCH(match_b),
        .RUN_VALID(run_valid_b), .RUN_LEN(run_len_b), .SAT(sat_b),
        .MATCH_CNT(match_cnt_b)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: length of the current run as an unbounded integer.
    int m_run;
    int m_run_len;
    bit m_match;
    bit m_valid;
    bit m_sat;
    int m_mcnt8;
    int m_mcnt2;

    task automatic model_reset();
        m_run = 0; m_run_len = 0; m_match = 0; m_valid = 0;
        m_sat = 0; m_mcnt8 = 0; m_mcnt2 = 0;
    endtask

    task automatic model_edge(input bit clr, input bit en, input bit b, input logic [31:0] mask);
        m_match = 0;
        m_valid = 0;
        if (clr) begin
            m_run = 0; m_sat = 0; m_mcnt8 = 0; m_mcnt2 = 0;
        end else if (en) begin
            if (b) begin
                m_run++;
                if (m_run >= MAXR) m_sat = 1;
            end else if (m_run > 0) begin
                m_valid   = 1;
                m_run_len = (m_run > MAXR) ? MAXR : m_run;
                m_match   = (m_run <= MAXR) && mask[m_run];
                if (m_match) begin
                    if (m_mcnt8 < 255) m_mcnt8++;
                    if (m_mcnt2 < 3)   m_mcnt2++;
                end
                m_run = 0;
            end
        end
    endtask

    task automatic compare_all();
        int exp_state;
        int exp_count;
        exp_state = (m_run == 0) ? 0 : ((m_run <= MAXR) ? 1 : 2);
        exp_count = (m_run > MAXR) ? MAXR : m_run;
        check("state",     32'(state_a),     32'(exp_state));
        check("count",     32'(count_a),     32'(exp_count));
        check("match",     32'(match_a),     32'(m_match));
        check("run_valid", 32'(run_valid_a), 32'(m_valid));
        check("run_len",   32'(run_len_a),   32'(m_run_len));
        check("sat",       32'(sat_a),       32'(m_sat));
        check("match_cnt", 32'(match_cnt_a), 32'(m_mcnt8));
        check("match_cnt_narrow", 32'(match_cnt_b), 32'(m_mcnt2));
    endtask

    // One clock edge: drive inputs, advance the model, sample 1 ns later.
    task automatic step(input bit en_i, input bit bit_i, input bit clr_i = 1'b0);
        EN  = en_i;
        BIT = bit_i;
        CLR = clr_i;
        @(posedge CLK);
        model_edge(clr_i, en_i, bit_i, LEN_MASK);
        #1;
        compare_all();
    endtask

    task automatic run_of(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1);
        step(1'b1, 1'b0);
    endtask

    initial begin
        RESET = 1'b1; CLR = 1'b0; EN = 1'b1; BIT = 1'b0; LEN_MASK = 32'h14;
        model_reset();
        #23;
        check("reset_state", 32'(state_a), 32'd0);
        check("reset_count", 32'(count_a), 32'd0);
        check("reset_run_len", 32'(run_len_a), 32'd0);
        check("reset_match_cnt", 32'(match_cnt_a), 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;

        // Run of two matches the default mask.
        step(1, 1); step(1, 1); step(1, 0);
        check("r2_match", 32'(match_a), 32'd1);
        check("r2_len", 32'(run_len_a), 32'd2);
        check("r2_cnt", 32'(match_cnt_a), 32'd1);
        step(1, 0);
        check("r2_match_drop", 32'(match_a), 32'd0);
        check("r2_len_hold", 32'(run_len_a), 32'd2);

        // Length 3 does not match, length 4 does.
        step(1, 0, 1);
        run_of(3);
        check("r3_valid", 32'(run_valid_a), 32'd1);
        check("r3_len", 32'(run_len_a), 32'd3);
        check("r3_match", 32'(match_a), 32'd0);
        run_of(4);
        check("r4_match", 32'(match_a), 32'd1);
        check("r4_len", 32'(run_len_a), 32'd4);
        check("r4_cnt", 32'(match_cnt_a), 32'd1);

        // Back-to-back single-bit runs give independent pulses.
        LEN_MASK = 32'h2;
        step(1, 1); step(1, 0);
        check("b2b_first", 32'(match_a), 32'd1);
        step(1, 1);
        check("b2b_gap", 32'(run_valid_a), 32'd0);
        step(1, 0);
        check("b2b_second", 32'(match_a), 32'd1);

        // Overflow: 40 ones, counter sticks at MAXR, no match on termination.
        LEN_MASK = 32'h8000_0014;
        step(1, 0, 1);
        for (int i = 0; i < 40; i++) step(1, 1);
        check("ovf_count", 32'(count_a), 32'(MAXR));
        check("ovf_state", 32'(state_a), 32'd2);
        check("ovf_sat", 32'(sat_a), 32'd1);
        step(1, 0);
        check("ovf_len", 32'(run_len_a), 32'(MAXR));
        check("ovf_match", 32'(match_a), 32'd0);
        check("ovf_valid", 32'(run_valid_a), 32'd1);
        check("ovf_sat_sticky", 32'(sat_a), 32'd1);

        // Exactly MAXR ones terminates from RUN, so bit 31 matches.
        run_of(MAXR);
        check("maxr_match", 32'(match_a), 32'd1);

        // Enable gap holds the run.
        LEN_MASK = 32'h14;
        step(1, 0, 1);
        step(1, 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0);
            check("gap_count", 32'(count_a), 32'd1);
        end
        step(1, 1); step(1, 0);
        check("gap_match", 32'(match_a), 32'd1);
        check("gap_len", 32'(run_len_a), 32'd2);

        // Asynchronous reset mid-run discards it.
        step(1, 1); step(1, 1);
        #2 RESET = 1'b1;
        #1;
        check("async_count", 32'(count_a), 32'd0);
        check("async_state", 32'(state_a), 32'd0);
        model_reset();
        #1 RESET = 1'b0;
        step(1, 0);
        check("async_no_valid", 32'(run_valid_a), 32'd0);
        check("async_no_match", 32'(match_a), 32'd0);

        // Narrow event counter saturates; CLR clears counters and SAT.
        step(1, 0, 1);
        for (int i = 0; i < 5; i++) begin
            run_of(2);
            check("narrow_cnt", 32'(match_cnt_b), 32'((i < 3) ? i + 1 : 3));
        end
        run_of(MAXR);
        check("pre_clr_sat", 32'(sat_b), 32'd1);
        step(1, 1, 1);
        check("clr_cnt", 32'(match_cnt_b), 32'd0);
        check("clr_sat", 32'(sat_b), 32'd0);
        check("clr_state", 32'(state_a), 32'd0);

        // Randomized traffic with varying run density, mask and disruptions.
        begin
            int p;
            p = 50;
            for (int i = 0; i < 4000; i++) begin
                if (i % 64 == 0) begin
                    case ($urandom_range(3))
                        0: p = 20;
                        1: p = 60;
                        2: p = 85;
                        default: p = 99;
                    endcase
                end
                if ($urandom_range(40) == 0) LEN_MASK = $urandom();
                if ($urandom_range(600) == 0) begin
                    RESET = 1'b1;
                    #2;
                    model_reset();
                    check("rand_async_count", 32'(count_a), 32'd0);
                    RESET = 1'b0;
                end
                step(($urandom_range(7) != 0), ($urandom_range(99) < p),
                     ($urandom_range(300) == 0));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
